// File: rtl/iddmm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iddmm_pkg
// Description : Shared constants and the shadow-pipeline entry type for the
//               IDDMM multiplier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package iddmm_pkg;

  localparam int MUL_W   = 128;
  localparam int PROD_W  = 256;
  localparam int MUL_LAT = 6;

  // Shadow entry fields are sized for up to 16 requesters and 8-bit tags;
  // narrower scheduler tags are zero-extended on entry and truncated on exit.
  localparam int SHADOW_ID_W  = 4;
  localparam int SHADOW_TAG_W = 8;

  typedef struct packed {
    logic                    valid;
    logic [SHADOW_ID_W-1:0]  req_id;
    logic [SHADOW_TAG_W-1:0] tag;
  } mul_shadow_t;

endpackage
`default_nettype wire

// File: rtl/iddmm_mul_128_to_256.sv
`default_nettype none
// ============================================================================
// Module      : iddmm_mul_128_to_256
// Description : Fully pipelined 128x128 -> 256 multiplier, fixed MUL_LAT
//               cycle latency, accepts a new operand pair every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module iddmm_mul_128_to_256
  import iddmm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] pipe [MUL_LAT];

  // Product enters stage 0 and ripples through the remaining stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < MUL_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= PROD_W'(a) * PROD_W'(b);
      for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign p = pipe[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/iddmm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iddmm_rr_arbiter
// Description : Combinational round-robin arbiter. Searches the eligible
//               vector starting at ptr and returns a one-hot grant plus the
//               pointer value to load if the grant is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module iddmm_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] next_ptr
);

  logic found;
  int   idx;

  // First eligible index at or after ptr wins; next pointer is one past it
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        next_ptr   = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iddmm_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : iddmm_mul_sched
// Description : Round-robin scheduler sharing one pipelined 128x128 multiplier
//               among NUM_REQ requesters, with a shadow pipeline carrying
//               {valid, req_id, tag} and per-requester outstanding limits.
//               Optional macro IDDMM_MUL_SCHED_ISSUE_REG_EN inserts a register
//               between the grant mux and the multiplier (latency 7 vs 6).
//               NUM_REQ <= 16 and TAG_W <= 8 fit the shadow entry fields.
// Revision    : 1.0 - initial release
// ============================================================================
module iddmm_mul_sched
  import iddmm_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_W     = 4,
  parameter int MAX_OUTST = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*MUL_W-1:0]   req_x,
  input  logic [NUM_REQ*MUL_W-1:0]   req_y,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic [PROD_W-1:0]          rsp_result,
  output logic                       idle
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       rr_ptr_next;
  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     rsp_hit;
  logic [3:0]             outst_cnt [NUM_REQ];
  logic                   rst_q;
  logic                   issue;
  logic [MUL_W-1:0]       sel_x;
  logic [MUL_W-1:0]       sel_y;
  logic [TAG_W-1:0]       sel_tag;
  logic [SHADOW_ID_W-1:0] sel_id;
  logic [MUL_W-1:0]       mul_a;
  logic [MUL_W-1:0]       mul_b;
  logic [PROD_W-1:0]      mul_p;
  logic                   any_valid;
  logic                   cnt_zero;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign eligible[i] = req_valid[i] && (outst_cnt[i] < 4'(MAX_OUTST));
  end

  iddmm_rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant),
    .next_ptr (rr_ptr_next)
  );

  // No grants while in reset or in the first cycle after it
  assign req_ready = (rst || rst_q) ? '0 : grant;
  assign issue     = |req_ready;

  // One-hot operand/tag mux; zero when nothing is granted
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_tag = '0;
    sel_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_x   = sel_x   | req_x[i*MUL_W +: MUL_W];
        sel_y   = sel_y   | req_y[i*MUL_W +: MUL_W];
        sel_tag = sel_tag | req_tag[i*TAG_W +: TAG_W];
        sel_id  = SHADOW_ID_W'(i);
      end
    end
  end

`ifdef IDDMM_MUL_SCHED_ISSUE_REG_EN
  localparam int SHADOW_DEPTH = MUL_LAT + 1;

  logic [MUL_W-1:0] issue_x;
  logic [MUL_W-1:0] issue_y;

  // Register the granted operands to take the mux off the multiplier path
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_x <= '0;
      issue_y <= '0;
    end else begin
      issue_x <= sel_x;
      issue_y <= sel_y;
    end
  end

  assign mul_a = issue_x;
  assign mul_b = issue_y;
`else
  localparam int SHADOW_DEPTH = MUL_LAT;

  assign mul_a = sel_x;
  assign mul_b = sel_y;
`endif

  iddmm_mul_128_to_256 u_mul (
    .clk   (clk),
    .rst_n (~rst),
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p)
  );

  mul_shadow_t shadow [SHADOW_DEPTH];
  mul_shadow_t tail;

  // Shadow pipeline tracks owner and tag of each product in step with the multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHADOW_DEPTH; k++) shadow[k] <= '0;
    end else begin
      shadow[0] <= {issue, sel_id, SHADOW_TAG_W'(sel_tag)};
      for (int k = 1; k < SHADOW_DEPTH; k++) shadow[k] <= shadow[k-1];
    end
  end

  assign tail = shadow[SHADOW_DEPTH-1];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_hit[i] = tail.valid && (tail.req_id == SHADOW_ID_W'(i));
  end

  assign rsp_valid  = rst ? '0 : rsp_hit;
  assign rsp_tag    = (tail.valid && !rst) ? TAG_W'(tail.tag) : '0;
  assign rsp_result = mul_p;

  // Outstanding counters: +1 on issue, -1 on response, hold when both coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) outst_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && !rsp_hit[i]) begin
          outst_cnt[i] <= outst_cnt[i] + 4'd1;
        end else if (!req_ready[i] && rsp_hit[i]) begin
          outst_cnt[i] <= outst_cnt[i] - 4'd1;
        end
      end
    end
  end

  // Round-robin pointer advances only on a transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= rr_ptr_next;
    end
  end

  // Delayed reset used to hold off grants for one cycle after release
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Idle when no shadow stage is valid and every counter is zero
  always_comb begin
    any_valid = 1'b0;
    cnt_zero  = 1'b1;
    for (int k = 0; k < SHADOW_DEPTH; k++) any_valid = any_valid | shadow[k].valid;
    for (int i = 0; i < NUM_REQ; i++) cnt_zero = cnt_zero & (outst_cnt[i] == 4'd0);
  end

  assign idle = rst || (!any_valid && cnt_zero);

endmodule
`default_nettype wire

// File: tb/tb_iddmm_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_iddmm_mul_sched
// Description : Directed self-checking bench for iddmm_mul_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iddmm_mul_sched;

`ifdef IDDMM_MUL_SCHED_ISSUE_REG_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_valid2;
  logic [511:0] req_x;
  logic [511:0] req_y;
  logic [15:0]  req_tag;
  wire  [3:0]   req_ready;
  wire  [3:0]   rsp_valid;
  wire  [3:0]   rsp_tag;
  wire  [255:0] rsp_result;
  wire          idle;
  wire  [3:0]   req_ready2;
  wire  [3:0]   rsp_valid2;
  wire  [3:0]   rsp_tag2;
  wire  [255:0] rsp_result2;
  wire          idle2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iddmm_mul_sched #(.NUM_REQ(4), .TAG_W(4), .MAX_OUTST(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .rsp_valid(rsp_valid),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result), .idle(idle)
  );

  iddmm_mul_sched #(.NUM_REQ(4), .TAG_W(4), .MAX_OUTST(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .rsp_valid(rsp_valid2),
    .rsp_tag(rsp_tag2), .rsp_result(rsp_result2), .idle(idle2)
  );

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of the first fully active cycle
  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_valid2 = '0;
    req_x = '0; req_y = '0; req_tag = '0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    next_cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_valid2 = '0;
    req_x = {4{128'h55}}; req_y = {4{128'h3}}; req_tag = 16'h1234;
    next_cyc();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_tag !== 4'h0) begin errors++; $display("FAIL reset_rsp_tag: got %h expected 0", rsp_tag); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL post_reset_ready: got %b expected 0000", req_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b expected 1", idle); end
    next_cyc();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b expected 0001", req_ready); end
    next_cyc();
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    req_x[127:0] = 128'd3; req_y[127:0] = 128'd5; req_tag[3:0] = 4'd2;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    next_cyc();
    req_valid = '0;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c < LAT) begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp c=%0d: got %b expected 0000", c, rsp_valid); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy c=%0d: got %b expected 0", c, idle); end
      end else if (c == LAT) begin
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid); end
        checks++; if (rsp_result !== 256'd15) begin errors++; $display("FAIL single_result: got %0d expected 15", rsp_result); end
        checks++; if (rsp_tag !== 4'd2) begin errors++; $display("FAIL single_tag: got %0d expected 2", rsp_tag); end
      end else begin
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_after: got %b expected 1", idle); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_after: got %b expected 0000", rsp_valid); end
        checks++; if (rsp_tag !== 4'd0) begin errors++; $display("FAIL single_tag_after: got %0d expected 0", rsp_tag); end
      end
      next_cyc();
    end
  endtask

  task automatic test_round_robin();
    int           n [4];
    logic [255:0] exp_p [12];
    logic [3:0]   exp_t [12];
    logic [127:0] xv;
    logic [127:0] yv;
    int           g;
    int           k;
    do_reset();
    for (int i = 0; i < 4; i++) n[i] = 0;
    for (int c = 0; c < 12 + LAT + 1; c++) begin
      req_valid = (c < 12) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++) begin
        req_x[i*128 +: 128] = {32'hA5A5_0000 + 32'(i), 64'h0, 32'(n[i] + 1)};
        req_y[i*128 +: 128] = {32'(n[i] + 3), 64'h1234, 32'(i + 9)};
        req_tag[i*4 +: 4]   = 4'(n[i] + i);
      end
      @(negedge clk);
      if (c < 12) begin
        g = c % 4;
        checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, 4'(1 << g)); end
        xv = {32'hA5A5_0000 + 32'(g), 64'h0, 32'(n[g] + 1)};
        yv = {32'(n[g] + 3), 64'h1234, 32'(g + 9)};
        exp_p[c] = {128'h0, xv} * {128'h0, yv};
        exp_t[c] = 4'(n[g] + g);
        n[g]++;
      end else begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_no_grant c=%0d: got %b expected 0000", c, req_ready); end
      end
      if (c >= LAT && c - LAT < 12) begin
        k = c - LAT;
        checks++; if (rsp_valid !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, 4'(1 << (k % 4))); end
        checks++; if (rsp_tag !== exp_t[k]) begin errors++; $display("FAIL rr_rsp_tag c=%0d: got %h expected %h", c, rsp_tag, exp_t[k]); end
        checks++; if (rsp_result !== exp_p[k]) begin errors++; $display("FAIL rr_rsp_result c=%0d: got %h expected %h", c, rsp_result, exp_p[k]); end
      end else begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rr_rsp_quiet c=%0d: got %b expected 0000", c, rsp_valid); end
      end
      next_cyc();
    end
  endtask

  task automatic test_max_operands();
    logic [255:0] exp_max;
    exp_max = {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h1};
    do_reset();
    req_valid = 4'b0100;
    req_x[256 +: 128] = '1; req_y[256 +: 128] = '1; req_tag[8 +: 4] = 4'hA;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL max_grant: got %b expected 0100", req_ready); end
    next_cyc();
    req_valid = '0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c == LAT) begin
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL max_rsp_valid: got %b expected 0100", rsp_valid); end
        checks++; if (rsp_result !== exp_max) begin errors++; $display("FAIL max_result: got %h expected %h", rsp_result, exp_max); end
        checks++; if (rsp_tag !== 4'hA) begin errors++; $display("FAIL max_tag: got %h expected a", rsp_tag); end
      end
      next_cyc();
    end
  endtask

  task automatic test_outst_limit();
    logic exp_rdy;
    do_reset();
    req_valid2 = 4'b0001;
    req_x[127:0] = 128'd7; req_y[127:0] = 128'd9; req_tag[3:0] = 4'd1;
    for (int c = 0; c < 17; c++) begin
      exp_rdy = ((c % (LAT + 1)) < 2);
      @(negedge clk);
      checks++; if (req_ready2 !== {3'b000, exp_rdy}) begin errors++; $display("FAIL limit_ready c=%0d: got %b expected %b", c, req_ready2, {3'b000, exp_rdy}); end
      next_cyc();
    end
    req_valid2 = '0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'(1 << c)) begin errors++; $display("FAIL mid_grant c=%0d: got %b expected %b", c, req_ready, 4'(1 << c)); end
      next_cyc();
    end
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_in_reset: got %b expected 0000", rsp_valid); end
    next_cyc();
    rst = 1'b0;
    for (int c = 4; c < 4 + LAT + 4; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp c=%0d: got %b expected 0000", c, rsp_valid); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle c=%0d: got %b expected 1", c, idle); end
      next_cyc();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_valid2 = '0;
    req_x = '0; req_y = '0; req_tag = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_max_operands();
    test_outst_limit();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
